// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the Booth multiplier control unit: one-hot state
// indices, state count and default operand width.
package alu_ctrl_pkg;

  localparam int STATE_N       = 9;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD   = 4'd1,
    S_CHECK  = 4'd2,
    S_ADD    = 4'd3,
    S_SUB    = 4'd4,
    S_SHIFT  = 4'd5,
    S_OUT_HI = 4'd6,
    S_OUT_LO = 4'd7,
    S_END    = 4'd8
  } state_idx_e;

  function automatic logic is_onehot(input logic [STATE_N-1:0] v);
    return (v != '0) && ((v & (v - STATE_N'(1))) == '0);
  endfunction

endpackage

// File: rtl/state_ff.sv
// One state bit of the one-hot controller: synchronous-reset flop with a
// load enable and a configurable reset value.
module state_ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/booth_control_unit.sv
// One-hot Booth multiplier sequencer: load, WIDTH check/add-sub/shift
// iterations, two result-bus cycles, then a one-cycle done.
module booth_control_unit
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               q0,
  input  logic               q_m1,
  output logic               load_en,
  output logic               add_en,
  output logic               sub_en,
  output logic               shift_en,
  output logic               out_hi,
  output logic               out_lo,
  output logic               busy,
  output logic               done,
  output logic [STATE_N-1:0] state
);

  logic [STATE_N-1:0] nxt;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_clr;
  logic               cnt_inc;

  for (genvar i = 0; i < STATE_N; i++) begin : g_state
    state_ff #(.RST_VAL(i == int'(S_IDLE))) u_ff (
      .clk  (clk),
      .reset(reset),
      .en   (1'b1),
      .d    (nxt[i]),
      .q    (state[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clr) cnt <= '0;
    else if (cnt_inc)     cnt <= cnt + CNT_W'(1);
  end

  always_comb begin
    nxt     = '0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (!is_onehot(state)) begin
      // Corrupted encoding: recover to a clean IDLE.
      nxt[S_IDLE] = 1'b1;
      cnt_clr     = 1'b1;
    end else if (state[S_IDLE]) begin
      if (start) nxt[S_LOAD] = 1'b1;
      else       nxt[S_IDLE] = 1'b1;
    end else if (state[S_LOAD]) begin
      nxt[S_CHECK] = 1'b1;
      cnt_clr      = 1'b1;
    end else if (state[S_CHECK]) begin
      case ({q0, q_m1})
        2'b01:   nxt[S_ADD]   = 1'b1;
        2'b10:   nxt[S_SUB]   = 1'b1;
        default: nxt[S_SHIFT] = 1'b1;
      endcase
    end else if (state[S_ADD] || state[S_SUB]) begin
      nxt[S_SHIFT] = 1'b1;
    end else if (state[S_SHIFT]) begin
      if (cnt == CNT_W'(WIDTH - 1)) begin
        nxt[S_OUT_HI] = 1'b1;
      end else begin
        nxt[S_CHECK] = 1'b1;
        cnt_inc      = 1'b1;
      end
    end else if (state[S_OUT_HI]) begin
      nxt[S_OUT_LO] = 1'b1;
    end else if (state[S_OUT_LO]) begin
      nxt[S_END] = 1'b1;
    end else begin
      nxt[S_IDLE] = 1'b1;
    end
  end

  assign load_en  = state[S_LOAD];
  assign add_en   = state[S_ADD];
  assign sub_en   = state[S_SUB];
  assign shift_en = state[S_SHIFT];
  assign out_hi   = state[S_OUT_HI];
  assign out_lo   = state[S_OUT_LO];
  assign done     = state[S_END];
  assign busy     = ~state[S_IDLE];

endmodule

// File: tb/tb_booth_control_unit.sv
// Self-checking bench for booth_control_unit: table-driven Booth patterns,
// reset/abort sequence, and back-to-back runs with start held high.
module tb_booth_control_unit;
  import alu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset, start, q0, q_m1;
  logic load_en, add_en, sub_en, shift_en, out_hi, out_lo, busy, done;
  logic [STATE_N-1:0] state;

  int ntests = 0;
  int nfail  = 0;
  bit mon_on = 1'b0;

  always #5 clk = ~clk;

  booth_control_unit #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .q0(q0), .q_m1(q_m1),
    .load_en(load_en), .add_en(add_en), .sub_en(sub_en),
    .shift_en(shift_en), .out_hi(out_hi), .out_lo(out_lo),
    .busy(busy), .done(done), .state(state)
  );

  typedef struct {
    string name;
    int    mode;
    int    exp_add;
    int    exp_sub;
    int    exp_shift;
    int    exp_lat;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    ntests++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // mode 0: 00, 1: 10, 2: 01/10 alternating, 3: 11, 4: 01
  function automatic logic [1:0] pat(input int mode, input int idx);
    case (mode)
      1:       return 2'b10;
      2:       return (idx % 2 == 0) ? 2'b01 : 2'b10;
      3:       return 2'b11;
      4:       return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic int outs();
    return int'({load_en, add_en, sub_en, shift_en, out_hi, out_lo, busy, done});
  endfunction

  // Structural invariants, independent of which run is in progress.
  always @(negedge clk) begin
    if (mon_on) begin
      check("onehot", $countones(state), 1);
      check("excl", int'($countones({load_en, add_en, sub_en, shift_en, out_hi, out_lo}) <= 1), 1);
      check("busy_dec", int'(busy), int'(!state[S_IDLE]));
      check("done_dec", int'(done), int'(state[S_END]));
    end
  end

  task automatic run_op(input int mode, output int adds, output int subs,
                        output int shifts, output int lat, output int dones);
    int chk;
    adds = 0; subs = 0; shifts = 0; lat = -1; dones = 0; chk = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      if (state[S_CHECK]) begin
        {q0, q_m1} = pat(mode, chk);
        chk++;
      end
      @(posedge clk); #1;
      adds   += int'(add_en);
      subs   += int'(sub_en);
      shifts += int'(shift_en);
      if (done) begin
        dones++;
        lat = e;
      end
      if (state[S_IDLE]) break;
    end
  endtask

  vec_t vecs[5];
  int a, s, sh, lat, dn, nchk;
  int done_at[$];
  int exp_q[$];

  initial begin
    vecs[0] = '{"pat00",  0, 0, 0, 8, 19};
    vecs[1] = '{"pat10",  1, 0, 8, 8, 27};
    vecs[2] = '{"patalt", 2, 4, 4, 8, 27};
    vecs[3] = '{"pat11",  3, 0, 0, 8, 19};
    vecs[4] = '{"pat01",  4, 8, 0, 8, 27};

    reset = 1'b1; start = 1'b0; q0 = 1'b0; q_m1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", int'(state), 1);
    check("rst_outs", outs(), 0);
    @(negedge clk) reset = 1'b0;
    mon_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_state", int'(state), 1);
      check("idle_outs", outs(), 0);
    end

    foreach (vecs[i]) begin
      run_op(vecs[i].mode, a, s, sh, lat, dn);
      check({vecs[i].name, "_add"},   a,   vecs[i].exp_add);
      check({vecs[i].name, "_sub"},   s,   vecs[i].exp_sub);
      check({vecs[i].name, "_shift"}, sh,  vecs[i].exp_shift);
      check({vecs[i].name, "_lat"},   lat, vecs[i].exp_lat);
      check({vecs[i].name, "_done1"}, dn,  1);
    end

    // Abort during the 4th CHECK, then a clean run must still take 19 edges.
    {q0, q_m1} = 2'b10;
    nchk = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int e = 0; e < 40 && nchk < 4; e++) begin
      @(posedge clk); #1;
      if (state[S_CHECK]) nchk++;
    end
    check("abort_reached", nchk, 4);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_state", int'(state), 1);
    check("abort_outs", outs(), 0);
    @(negedge clk) reset = 1'b0;
    run_op(0, a, s, sh, lat, dn);
    check("post_abort_shift", sh, 8);
    check("post_abort_lat", lat, 19);

    // Start held high: END every 21 edges; start ignored while busy.
    {q0, q_m1} = 2'b00;
    exp_q = '{19, 40, 61};
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int e = 1; e <= 65; e++) begin
      @(posedge clk); #1;
      if (done) done_at.push_back(e);
    end
    @(negedge clk); start = 1'b0;
    for (int e = 0; e < 30 && !state[S_IDLE]; e++) @(posedge clk);
    #1;
    check("b2b_count", done_at.size(), exp_q.size());
    while (exp_q.size() > 0 && done_at.size() > 0)
      check("b2b_edge", done_at.pop_front(), exp_q.pop_front());
    check("b2b_idle", int'(state), 1);

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/booth_control_unit.md
BOOTH_CONTROL_UNIT -- requirements
Module: booth_control_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width; one Booth iteration per bit.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH): iteration counter width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin a multiply; sampled only in IDLE.
REQ-006 SHALL have ports q0 and q_m1, inputs, 1 bit each: Booth pair from the datapath Q register LSB and Q(-1) bit.
REQ-007 SHALL have port load_en, output, 1 bit: load M and Q, clear A and Q(-1).
REQ-008 SHALL have ports add_en and sub_en, outputs, 1 bit each: A <= A+M and A <= A-M respectively.
REQ-009 SHALL have port shift_en, output, 1 bit: arithmetic right shift of {A,Q,Q(-1)}.
REQ-010 SHALL have ports out_hi and out_lo, outputs, 1 bit each: drive A, then Q, onto the result bus.
REQ-011 SHALL have ports busy and done, outputs, 1 bit each: busy is high in every state except IDLE; done is high in END only.
REQ-012 SHALL have port state, output, 9 bits: one-hot state vector for observation.

Function
REQ-013 SHALL implement one-hot states IDLE, LOAD, CHECK, ADD, SUB, SHIFT, OUT_HI, OUT_LO, END, with one flip-flop per state.
REQ-014 SHALL make all control outputs Moore outputs decoded from the state: load_en=LOAD, add_en=ADD, sub_en=SUB, shift_en=SHIFT, out_hi=OUT_HI, out_lo=OUT_LO, done=END.
REQ-015 SHALL move from IDLE to LOAD when start=1; with start=0 it SHALL stay in IDLE.
REQ-016 SHALL ignore start in every state except IDLE.
REQ-017 SHALL move from LOAD to CHECK and clear the iteration counter to 0.
REQ-018 SHALL sample {q0,q_m1} only in CHECK: 01 -> ADD; 10 -> SUB; 00 or 11 -> SHIFT.
REQ-019 SHALL move from ADD to SHIFT, and from SUB to SHIFT, unconditionally.
REQ-020 SHALL, in SHIFT, go to OUT_HI when counter == WIDTH-1; otherwise it SHALL increment the counter and go to CHECK.
REQ-021 SHALL step OUT_HI -> OUT_LO -> END -> IDLE, one cycle each.
REQ-022 SHALL give a latency, from the edge that samples start to the edge that enters END, of 2*WIDTH+3 edges plus one edge per ADD/SUB visit: 19 minimum and 27 maximum at WIDTH=8.
REQ-023 SHALL have exactly one state bit high at all times; any other encoding SHALL go to IDLE on the next edge with the counter cleared.
REQ-024 SHALL assert at most one of load_en, add_en, sub_en, shift_en, out_hi, out_lo in any cycle.
REQ-025 SHALL, with start held high, re-launch from IDLE, giving back-to-back runs with one IDLE cycle between END and LOAD.

Reset
REQ-026 SHALL, on reset=1 at a rising edge, enter IDLE (state = IDLE bit only), clear the counter, and drive all control outputs, busy and done to 0.
REQ-027 SHALL give reset priority over start and over any transition, including reset asserted mid-operation.
REQ-028 SHALL start the first operation after reset with a fresh counter, so an aborted run leaves no residue.

Structure
REQ-029 SHALL place the state index constants, the STATE_N=9 constant and the default WIDTH in shared package alu_ctrl_pkg.
REQ-030 SHALL build each state bit from sub-module state_ff: a sync-reset flip-flop with load enable and a parameter RST_VAL, which is 1 for IDLE and 0 for all other states.
REQ-031 SHALL keep the next-state logic and output decode combinational, inside booth_control_unit.

Verification
REQ-032 SHALL cover: reset, then start=0 for 10 cycles -> state=IDLE, all outputs 0, busy=0.
REQ-033 SHALL cover: start pulse, {q0,q_m1}=00 constant -> 8 shift_en pulses, 0 add_en/sub_en, done high one cycle 19 edges after the start-sampling edge.
REQ-034 SHALL cover: {q0,q_m1}=10 constant -> 8 sub_en, 8 shift_en, done 27 edges after start.
REQ-035 SHALL cover: {q0,q_m1} alternating 01/10 per CHECK -> 4 add_en, 4 sub_en, done 27 edges after start.
REQ-036 SHALL cover: reset during the 4th CHECK -> IDLE next cycle, outputs 0; a following start completes in 19 edges with pattern 00.
REQ-037 SHALL cover: start held high, pattern 00 -> done every 21 edges, with one-hot and output-exclusivity assertions passing throughout.
